qsn_shift_sched_pc5: RTL and testbench
======================================

Name: qsn_shift_sched_pc5

Overview:
- Sequences the Pc=5 quasi-cyclic shift network (QSN): a left shifter, a right shifter and a merge stage.
- Holds a programmable per-column circulant shift table for one layer.
- On start, walks the table and issues one registered QSN configuration per non-null submatrix (left_sel, right_sel, merge_mask) over a valid/ready handshake.
- Sits between the layer controller and the QSN datapath of the low-end partial message-passing decoder.

Parameters:
- Z, 5, circulant size; the QSN input width.
- SEL_W, 3, width of the shift factors and selects; must satisfy 2^SEL_W > Z.
- COL_NUM, 8, number of table entries (block columns per layer).
- ADDR_W, 3, table address width; must satisfy 2^ADDR_W >= COL_NUM.
- NULL_SHIFT, 7, shift code marking an all-zero submatrix (skipped).

Ports:
- sys_clk  in  1  clock; everything samples on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  ADDR_W  table write address.
- cfg_shift  in  SEL_W  shift factor to write.
- cfg_err  out  1  one-cycle pulse on a rejected write.
- start  in  1  begin a layer sweep; sampled in IDLE only.
- busy  out  1  high in RUN or DONE.
- done  out  1  one-cycle pulse when the sweep completes.
- out_valid  out  1  configuration valid.
- out_ready  in  1  QSN/consumer accepts the configuration.
- out_col  out  ADDR_W  table index of the issued entry.
- left_sel  out  SEL_W  left shifter select.
- right_sel  out  SEL_W  right shifter select.
- merge_mask  out  Z  bit i = 1: lane i comes from the left shifter; 0: lane i comes from the right shifter.

Behaviour:
- Reset (async, rstn=0):
  - State is IDLE; all outputs are 0.
  - Table entries reset to NULL_SHIFT; scan index is 0.
- Table write, accepted only in IDLE with cfg_addr < COL_NUM:
  - cfg_shift < Z: stored as-is.
  - cfg_shift == NULL_SHIFT: stored as null.
  - Any other value: stored as NULL_SHIFT and cfg_err pulses.
  - Writes with cfg_addr >= COL_NUM, or made while busy, are dropped and cfg_err pulses the next cycle.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: start=1 sets scan index to 0 and moves to RUN next cycle. cfg_we and start in the same cycle: the write commits first and start is honoured.
  - RUN: the output register is loadable when out_valid=0 or (out_valid & out_ready).
    - When loadable, the entry at the scan index is examined and the index increments. A null entry is skipped at one entry per cycle and produces no output.
    - A non-null entry s loads: left_sel=s; right_sel=(s==0)?0:Z-s; merge_mask bit i = 1 for i < Z-s (s=0 gives all ones); out_col=index. out_valid is set.
    - Latency: start to first out_valid is at least 2 cycles.
    - With out_ready held high, one entry is issued per cycle.
  - Leaving RUN: once the index passes COL_NUM-1 and no configuration is pending (out_valid=0 or being accepted), move to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - All-null table: RUN scans COL_NUM cycles, then done, with no out_valid.
- Handshake: while out_valid=1 and out_ready=0, out_valid, out_col and all selects hold stable; out_valid never drops without a handshake.
- start in RUN or DONE is ignored.
- busy = (state != IDLE).

Optional Feature:
- Macro: QSN_SHIFT_ACCUM_EN.
- Defined (differential shifting for layered decoding, messages kept in the previous layer's rotation):
  - The effective shift is d = (s - prev) mod Z, computed without negative intermediates as s + Z - prev, minus Z if >= Z.
  - prev is cleared to 0 when a sweep starts and updated to s on each issued (non-null) entry.
  - left_sel, right_sel and merge_mask derive from d instead of s.
- Undefined: absolute shifting as described under Behaviour; no prev register exists.

Test Plan:
1. Reset mid-sweep (rstn low while out_valid=1) -> out_valid, busy and done are 0 immediately; the table reads all-null on the next sweep.
2. Program [0,3,7,1,4,2,7,0], start, out_ready=1 -> six issues, in order (col, left_sel, right_sel, mask):
   - (0, 0, 0, 11111)
   - (1, 3, 2, 00011)
   - (3, 1, 4, 01111)
   - (4, 4, 1, 00001)
   - (5, 2, 3, 00111)
   - (7, 0, 0, 11111)
   - followed by a single done pulse.
3. Same table, out_ready=0 for 5 cycles after the first out_valid -> the col 0 config holds stable; no entry is lost or duplicated afterwards.
4. cfg_shift=5 at addr 2, a write to addr 9 (COL_NUM=8), and a write while busy -> cfg_err pulses for each; the table is unchanged except addr 2 = null.
5. All-null table, start -> busy for COL_NUM+1 cycles, no out_valid, one done pulse; start during busy is ignored.
6. QSN_SHIFT_ACCUM_EN, table [0,3,7,1,4,2,7,0] -> d sequence 0,3,3,3,3,3; at col 1, left_sel=3 and mask=00011.

Source files
------------

// File: rtl/qsn_shift_sched_pc5.sv
// Shift-table scheduler for the Pc=5 quasi-cyclic shift network: walks one layer's
// circulant table and issues (left_sel, right_sel, merge_mask) per non-null entry.
// Optional feature macro: QSN_SHIFT_ACCUM_EN (differential shifting against the previous entry).
module qsn_shift_sched_pc5 #(
    parameter int Z          = 5,
    parameter int SEL_W      = 3,
    parameter int COL_NUM    = 8,
    parameter int ADDR_W     = 3,
    parameter int NULL_SHIFT = 7
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [SEL_W-1:0]  cfg_shift,
    output logic              cfg_err,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_col,
    output logic [SEL_W-1:0]  left_sel,
    output logic [SEL_W-1:0]  right_sel,
    output logic [Z-1:0]      merge_mask
);

    localparam int IDX_W = ADDR_W + 1;
    localparam logic [SEL_W-1:0] NULL_CODE = SEL_W'(NULL_SHIFT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  col_q, col_d;
    logic [SEL_W-1:0]   left_q, left_d;
    logic [SEL_W-1:0]   right_q, right_d;
    logic [Z-1:0]       mask_q, mask_d;
    logic               err_q, err_d;
    logic [SEL_W-1:0]   tbl_q [COL_NUM];

    logic               addr_ok, shift_ok, shift_null, wr_en;
    logic [SEL_W-1:0]   wr_data;
    logic               in_range, loadable;
    logic [SEL_W-1:0]   entry, eff_s, right_new;
    logic [SEL_W:0]     mask_lim;
    logic [Z-1:0]       mask_new;

    assign addr_ok    = IDX_W'(cfg_addr) < IDX_W'(COL_NUM);
    assign shift_ok   = cfg_shift < SEL_W'(Z);
    assign shift_null = cfg_shift == NULL_CODE;
    assign wr_en      = cfg_we && (state_q == S_IDLE) && addr_ok;
    assign wr_data    = shift_ok ? cfg_shift : NULL_CODE;
    assign err_d      = cfg_we && (!wr_en || (!shift_ok && !shift_null));

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < COL_NUM; i++) tbl_q[i] <= NULL_CODE;
        end else begin
            for (int i = 0; i < COL_NUM; i++)
                if (wr_en && cfg_addr == ADDR_W'(i)) tbl_q[i] <= wr_data;
        end
    end

    assign in_range = idx_q < IDX_W'(COL_NUM);

    always_comb begin
        entry = NULL_CODE;
        for (int i = 0; i < COL_NUM; i++)
            if (idx_q == IDX_W'(i)) entry = tbl_q[i];
    end

`ifdef QSN_SHIFT_ACCUM_EN
    // Messages already sit rotated by the previous entry, so only the delta is applied.
    logic [SEL_W-1:0] prev_q, prev_d;
    logic [SEL_W:0]   diff;
    assign diff  = {1'b0, entry} + (SEL_W+1)'(Z) - {1'b0, prev_q};
    assign eff_s = (diff >= (SEL_W+1)'(Z)) ? SEL_W'(diff - (SEL_W+1)'(Z)) : SEL_W'(diff);

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) prev_q <= '0;
        else       prev_q <= prev_d;
    end

    always_comb begin
        prev_d = prev_q;
        if (state_q == S_IDLE && start)
            prev_d = '0;
        else if (state_q == S_RUN && loadable && in_range && entry != NULL_CODE)
            prev_d = entry;
    end
`else
    assign eff_s = entry;
`endif

    assign right_new = (eff_s == '0) ? '0 : SEL_W'(Z) - eff_s;
    assign mask_lim  = (SEL_W+1)'(Z) - {1'b0, eff_s};

    generate
        for (genvar gi = 0; gi < Z; gi++) begin : g_mask
            assign mask_new[gi] = (SEL_W+1)'(gi) < mask_lim;
        end
    endgenerate

    assign loadable = !valid_q || out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        col_d   = col_q;
        left_d  = left_q;
        right_d = right_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (loadable) begin
                    valid_d = 1'b0;
                    if (!in_range) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (entry != NULL_CODE) begin
                            valid_d = 1'b1;
                            col_d   = ADDR_W'(idx_q);
                            left_d  = eff_s;
                            right_d = right_new;
                            mask_d  = mask_new;
                        end else if (idx_q == IDX_W'(COL_NUM - 1)) begin
                            // Trailing null entry: nothing pending, finish without an extra cycle.
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            col_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            col_q   <= col_d;
            left_q  <= left_d;
            right_q <= right_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

    assign cfg_err    = err_q;
    assign busy       = state_q != S_IDLE;
    assign done       = state_q == S_DONE;
    assign out_valid  = valid_q;
    assign out_col    = col_q;
    assign left_sel   = left_q;
    assign right_sel  = right_q;
    assign merge_mask = mask_q;

endmodule

// File: tb/tb_qsn_shift_sched_pc5.sv
// Scoreboard bench for qsn_shift_sched_pc5; ADDR_W widened to 4 so out-of-range addresses are reachable.
module tb_qsn_shift_sched_pc5;

    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] col;
        logic [2:0]    l;
        logic [2:0]    r;
        logic [4:0]    m;
    } cfg_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [2:0]    cfg_shift = '0;
    logic          cfg_err;
    logic          start = 1'b0;
    logic          busy, done, out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_col;
    logic [2:0]    left_sel, right_sel;
    logic [4:0]    merge_mask;

    int   vec_cnt  = 0;
    int   miss_cnt = 0;
    int   done_cnt = 0;
    cfg_t exp_q[$];

    qsn_shift_sched_pc5 #(
        .Z(5), .SEL_W(3), .COL_NUM(8), .ADDR_W(AW), .NULL_SHIFT(7)
    ) dut (
        .sys_clk(clk), .rstn(rstn),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_shift(cfg_shift), .cfg_err(cfg_err),
        .start(start), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
        .left_sel(left_sel), .right_sel(right_sel), .merge_mask(merge_mask)
    );

    always #5 clk = ~clk;

    // Monitor: compares every presented configuration with the scoreboard head.
    always @(negedge clk) begin
        if (rstn) begin
            if (done) done_cnt++;
            if (out_valid) begin
                cfg_t got;
                got = '{out_col, left_sel, right_sel, merge_mask};
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    miss_cnt++;
                    $display("FAIL issue_unexpected: got col=%0d l=%0d r=%0d m=%b, required no output",
                             out_col, left_sel, right_sel, merge_mask);
                end else begin
                    if (got !== exp_q[0]) begin
                        miss_cnt++;
                        $display("FAIL issue: got col=%0d l=%0d r=%0d m=%b, required col=%0d l=%0d r=%0d m=%b",
                                 got.col, got.l, got.r, got.m,
                                 exp_q[0].col, exp_q[0].l, exp_q[0].r, exp_q[0].m);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        vec_cnt++;
        if (act != req) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic cfg_write(input int a, input int s, input int exp_err);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(a);
        cfg_shift = 3'(s);
        tick();
        cfg_we = 1'b0;
        check($sformatf("cfg_err addr=%0d shift=%0d", a, s), int'(cfg_err), exp_err);
    endtask

    task automatic load_table();
        int t[8] = '{0, 3, 7, 1, 4, 2, 7, 0};
        for (int i = 0; i < 8; i++) cfg_write(i, t[i], 0);
    endtask

    task automatic push_list();
`ifdef QSN_SHIFT_ACCUM_EN
        exp_q.push_back(cfg_t'{4'd0, 3'd0, 3'd0, 5'b11111});
        exp_q.push_back(cfg_t'{4'd1, 3'd3, 3'd2, 5'b00011});
        exp_q.push_back(cfg_t'{4'd3, 3'd3, 3'd2, 5'b00011});
        exp_q.push_back(cfg_t'{4'd4, 3'd3, 3'd2, 5'b00011});
        exp_q.push_back(cfg_t'{4'd5, 3'd3, 3'd2, 5'b00011});
        exp_q.push_back(cfg_t'{4'd7, 3'd3, 3'd2, 5'b00011});
`else
        exp_q.push_back(cfg_t'{4'd0, 3'd0, 3'd0, 5'b11111});
        exp_q.push_back(cfg_t'{4'd1, 3'd3, 3'd2, 5'b00011});
        exp_q.push_back(cfg_t'{4'd3, 3'd1, 3'd4, 5'b01111});
        exp_q.push_back(cfg_t'{4'd4, 3'd4, 3'd1, 5'b00001});
        exp_q.push_back(cfg_t'{4'd5, 3'd2, 3'd3, 5'b00111});
        exp_q.push_back(cfg_t'{4'd7, 3'd0, 3'd0, 5'b11111});
`endif
    endtask

    task automatic wait_valid();
        int n;
        for (n = 0; n < 20 && !out_valid; n++) tick();
        if (!out_valid) begin
            miss_cnt++;
            $display("FAIL wait_valid: got timeout after %0d cycles, required out_valid", n);
        end
    endtask

    // Starts a sweep; optionally stalls the first issue and/or writes while busy.
    task automatic run_sweep(input string name, input int hold, input bit busy_wr);
        int d0, n;
        d0 = done_cnt;
        if (hold > 0) out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (busy_wr) cfg_write(0, 4, 1);
        if (hold > 0) begin
            wait_valid();
            repeat (hold) tick();
            out_ready = 1'b1;
        end
        for (n = 0; n < 100 && done_cnt == d0; n++) tick();
        repeat (3) tick();
        check({name, " done_pulses"}, done_cnt - d0, 1);
        check({name, " pending_expected"}, exp_q.size(), 0);
    endtask

    initial begin
        int d0, busy_cyc;

        repeat (3) tick();
        rstn = 1'b1;
        tick();
        check("reset out_valid", int'(out_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);

        // Reset mid-sweep while a configuration is pending.
        load_table();
        push_list();
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid();
        #2;
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("midreset out_valid", int'(out_valid), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        tick();
        rstn = 1'b1;
        out_ready = 1'b1;
        tick();

        // Table is all-null after reset: busy COL_NUM+1 cycles, start during busy ignored.
        d0 = done_cnt;
        start = 1'b1;
        tick();
        busy_cyc = 0;
        for (int i = 0; i < 30; i++) begin
            start = (i == 3);
            @(negedge clk);
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("allnull busy_cycles", busy_cyc, 9);
        check("allnull done_pulses", done_cnt - d0, 1);

        // Streaming sweep with out_ready held high.
        load_table();
        push_list();
        run_sweep("stream", 0, 1'b0);

        // Back-pressure on the first issue for 5 cycles.
        push_list();
        run_sweep("stall", 5, 1'b0);

        // Rejected writes: bad shift, out-of-range address, write while busy.
        cfg_write(2, 2, 0);
        cfg_write(2, 5, 1);
        tick();
        check("cfg_err one_cycle", int'(cfg_err), 0);
        cfg_write(9, 1, 1);
        push_list();
        run_sweep("busywrite", 0, 1'b1);
        push_list();
        run_sweep("after_errors", 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
